vme_a16_master: RTL and testbench

Single-master VME A16/D16 bus-cycle initiator for the EA4163 test fixture. It turns one local request into a full VME data-transfer cycle: address/AM setup, AS*, DS0*/DS1*, wait for DTACK*/BERR*, release. It is the counterpart of the board's VME slave decoder and drives that slave's AS/DS/WR/A/AM/D inputs from the bench or controller side. It executes one transfer at a time and returns read data plus a status code.

---
 rtl/vme_a16_master.sv | 248 ++++++++++++++++++++++++
 tb/tb_vme_a16_master.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vme_a16_master.sv
// VME A16/D16 single-master cycle initiator: one local request becomes one full
// address/AS*/DS* handshake, returning read data and a completion status.
module vme_a16_master #(
    parameter int ADDR_SETUP = 2,
    parameter int TIMEOUT    = 512
) (
    input  logic        I_CLK_32M,
    input  logic        I_VME_SYSRESET,
    input  logic        I_REQ,
    input  logic        I_REQ_WR,
    input  logic [14:0] I_REQ_ADDR,
    input  logic [5:0]  I_REQ_AM,
    input  logic [1:0]  I_REQ_BE,
    input  logic [15:0] I_REQ_DATA,
    output logic        O_BUSY,
    output logic        O_DONE,
    output logic [1:0]  O_STATUS,
    output logic [15:0] O_RD_DATA,
    output logic        O_VME_AS,
    output logic        O_VME_DS0,
    output logic        O_VME_DS1,
    output logic        O_VME_WR,
    output logic        O_VME_LWORD,
    output logic [14:0] O_VME_A,
    output logic [5:0]  O_VME_AM,
    output logic [15:0] O_VME_D,
    output logic        O_VME_D_OE,
    input  logic [15:0] I_VME_D,
    input  logic        I_VME_DTACK,
    input  logic        I_VME_BERR
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SETUP    = 3'd1;
    localparam logic [2:0] S_ASSERT   = 3'd2;
    localparam logic [2:0] S_STROBE   = 3'd3;
    localparam logic [2:0] S_WAIT_ACK = 3'd4;
    localparam logic [2:0] S_RELEASE  = 3'd5;
    localparam logic [2:0] S_WAIT_REL = 3'd6;
    localparam logic [2:0] S_FINISH   = 3'd7;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_BERR    = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;
    localparam logic [1:0] ST_BAD_BE  = 2'b11;

    localparam logic [15:0] SETUP_LAST   = 16'(ADDR_SETUP);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

    logic [2:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d, cnt_inc;
    logic        req_wr_q, req_wr_d;
    logic [14:0] req_addr_q, req_addr_d;
    logic [5:0]  req_am_q, req_am_d;
    logic [1:0]  req_be_q, req_be_d;
    logic [15:0] req_data_q, req_data_d;
    logic        vme_as_q, vme_as_d;
    logic        vme_ds0_q, vme_ds0_d;
    logic        vme_ds1_q, vme_ds1_d;
    logic        vme_wr_q, vme_wr_d;
    logic [14:0] vme_a_q, vme_a_d;
    logic [5:0]  vme_am_q, vme_am_d;
    logic [15:0] vme_d_q, vme_d_d;
    logic        vme_d_oe_q, vme_d_oe_d;
    logic [1:0]  status_q, status_d;
    logic [15:0] rd_buf_q, rd_buf_d;
    logic [1:0]  status_out_q, status_out_d;
    logic [15:0] rd_data_q, rd_data_d;
    logic        done_q, done_d;
    logic        dtack_meta_q, dtack_sync_q;
    logic        berr_meta_q, berr_sync_q;

    // Counter saturates so a stuck responder can never wrap it back under the limit.
    assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_inc;
        req_wr_d     = req_wr_q;
        req_addr_d   = req_addr_q;
        req_am_d     = req_am_q;
        req_be_d     = req_be_q;
        req_data_d   = req_data_q;
        vme_as_d     = vme_as_q;
        vme_ds0_d    = vme_ds0_q;
        vme_ds1_d    = vme_ds1_q;
        vme_wr_d     = vme_wr_q;
        vme_a_d      = vme_a_q;
        vme_am_d     = vme_am_q;
        vme_d_d      = vme_d_q;
        vme_d_oe_d   = vme_d_oe_q;
        status_d     = status_q;
        rd_buf_d     = rd_buf_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (I_REQ) begin
                    req_wr_d   = I_REQ_WR;
                    req_addr_d = I_REQ_ADDR;
                    req_am_d   = I_REQ_AM;
                    req_be_d   = I_REQ_BE;
                    req_data_d = I_REQ_DATA;
                    if (I_REQ_BE == 2'b00) begin
                        status_d = ST_BAD_BE;
                        state_d  = S_FINISH;
                    end else begin
                        state_d  = S_SETUP;
                    end
                end
            end
            S_SETUP: begin
                vme_a_d  = req_addr_q;
                vme_am_d = req_am_q;
                vme_wr_d = ~req_wr_q;
                if (req_wr_q) begin
                    vme_d_d    = req_data_q;
                    vme_d_oe_d = 1'b1;
                end
                if (cnt_q == SETUP_LAST) begin
                    vme_as_d = 1'b0;
                    state_d  = S_ASSERT;
                end
            end
            S_ASSERT: begin
                vme_ds0_d = ~req_be_q[0];
                vme_ds1_d = ~req_be_q[1];
                state_d   = S_STROBE;
            end
            S_STROBE: begin
                cnt_d   = '0;
                state_d = S_WAIT_ACK;
            end
            // BERR is tested ahead of DTACK so a simultaneous error is never reported as ok.
            S_WAIT_ACK: begin
                if (!berr_sync_q) begin
                    status_d = ST_BERR;
                    state_d  = S_RELEASE;
                end else if (!dtack_sync_q) begin
                    status_d = ST_OK;
                    if (!req_wr_q) begin
                        rd_buf_d = I_VME_D;
                    end
                    state_d  = S_RELEASE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    status_d = ST_TIMEOUT;
                    state_d  = S_RELEASE;
                end
                if (state_d == S_RELEASE) begin
                    vme_as_d  = 1'b1;
                    vme_ds0_d = 1'b1;
                    vme_ds1_d = 1'b1;
                end
            end
            S_RELEASE: begin
                cnt_d      = '0;
                vme_d_oe_d = 1'b0;
                state_d    = S_WAIT_REL;
            end
            S_WAIT_REL: begin
                if (dtack_sync_q && berr_sync_q) begin
                    state_d = S_FINISH;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    status_d = ST_TIMEOUT;
                    state_d  = S_FINISH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Results become visible together with the DONE pulse and stay put until the next one.
    always_comb begin
        done_d       = (state_q == S_FINISH);
        status_out_d = (state_q == S_FINISH) ? status_q : status_out_q;
        rd_data_d    = (state_q == S_FINISH) ? rd_buf_q : rd_data_q;
    end

    always_ff @(posedge I_CLK_32M or negedge I_VME_SYSRESET) begin
        if (!I_VME_SYSRESET) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            req_wr_q     <= 1'b0;
            req_addr_q   <= '0;
            req_am_q     <= '0;
            req_be_q     <= '0;
            req_data_q   <= '0;
            vme_as_q     <= 1'b1;
            vme_ds0_q    <= 1'b1;
            vme_ds1_q    <= 1'b1;
            vme_wr_q     <= 1'b1;
            vme_a_q      <= '0;
            vme_am_q     <= '0;
            vme_d_q      <= '0;
            vme_d_oe_q   <= 1'b0;
            status_q     <= ST_OK;
            rd_buf_q     <= '0;
            status_out_q <= ST_OK;
            rd_data_q    <= '0;
            done_q       <= 1'b0;
            dtack_meta_q <= 1'b1;
            dtack_sync_q <= 1'b1;
            berr_meta_q  <= 1'b1;
            berr_sync_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_wr_q     <= req_wr_d;
            req_addr_q   <= req_addr_d;
            req_am_q     <= req_am_d;
            req_be_q     <= req_be_d;
            req_data_q   <= req_data_d;
            vme_as_q     <= vme_as_d;
            vme_ds0_q    <= vme_ds0_d;
            vme_ds1_q    <= vme_ds1_d;
            vme_wr_q     <= vme_wr_d;
            vme_a_q      <= vme_a_d;
            vme_am_q     <= vme_am_d;
            vme_d_q      <= vme_d_d;
            vme_d_oe_q   <= vme_d_oe_d;
            status_q     <= status_d;
            rd_buf_q     <= rd_buf_d;
            status_out_q <= status_out_d;
            rd_data_q    <= rd_data_d;
            done_q       <= done_d;
            dtack_meta_q <= I_VME_DTACK;
            dtack_sync_q <= dtack_meta_q;
            berr_meta_q  <= I_VME_BERR;
            berr_sync_q  <= berr_meta_q;
        end
    end

    assign O_BUSY      = (state_q != S_IDLE);
    assign O_DONE      = done_q;
    assign O_STATUS    = status_out_q;
    assign O_RD_DATA   = rd_data_q;
    assign O_VME_AS    = vme_as_q;
    assign O_VME_DS0   = vme_ds0_q;
    assign O_VME_DS1   = vme_ds1_q;
    assign O_VME_WR    = vme_wr_q;
    assign O_VME_LWORD = 1'b1;
    assign O_VME_A     = vme_a_q;
    assign O_VME_AM    = vme_am_q;
    assign O_VME_D     = vme_d_q;
    assign O_VME_D_OE  = vme_d_oe_q;

endmodule

// File: tb/tb_vme_a16_master.sv
// Directed bench for vme_a16_master: hand-timed responder actions and checks,
// with TIMEOUT shortened to 16 so the timeout paths stay short.
module tb_vme_a16_master;

    logic        I_CLK_32M;
    logic        I_VME_SYSRESET;
    logic        I_REQ;
    logic        I_REQ_WR;
    logic [14:0] I_REQ_ADDR;
    logic [5:0]  I_REQ_AM;
    logic [1:0]  I_REQ_BE;
    logic [15:0] I_REQ_DATA;
    logic        O_BUSY;
    logic        O_DONE;
    logic [1:0]  O_STATUS;
    logic [15:0] O_RD_DATA;
    logic        O_VME_AS;
    logic        O_VME_DS0;
    logic        O_VME_DS1;
    logic        O_VME_WR;
    logic        O_VME_LWORD;
    logic [14:0] O_VME_A;
    logic [5:0]  O_VME_AM;
    logic [15:0] O_VME_D;
    logic        O_VME_D_OE;
    logic [15:0] I_VME_D;
    logic        I_VME_DTACK;
    logic        I_VME_BERR;

    int vectors;
    int miscompares;
    int cycles;

    vme_a16_master #(.ADDR_SETUP(2), .TIMEOUT(16)) dut (
        .I_CLK_32M      (I_CLK_32M),
        .I_VME_SYSRESET (I_VME_SYSRESET),
        .I_REQ          (I_REQ),
        .I_REQ_WR       (I_REQ_WR),
        .I_REQ_ADDR     (I_REQ_ADDR),
        .I_REQ_AM       (I_REQ_AM),
        .I_REQ_BE       (I_REQ_BE),
        .I_REQ_DATA     (I_REQ_DATA),
        .O_BUSY         (O_BUSY),
        .O_DONE         (O_DONE),
        .O_STATUS       (O_STATUS),
        .O_RD_DATA      (O_RD_DATA),
        .O_VME_AS       (O_VME_AS),
        .O_VME_DS0      (O_VME_DS0),
        .O_VME_DS1      (O_VME_DS1),
        .O_VME_WR       (O_VME_WR),
        .O_VME_LWORD    (O_VME_LWORD),
        .O_VME_A        (O_VME_A),
        .O_VME_AM       (O_VME_AM),
        .O_VME_D        (O_VME_D),
        .O_VME_D_OE     (O_VME_D_OE),
        .I_VME_D        (I_VME_D),
        .I_VME_DTACK    (I_VME_DTACK),
        .I_VME_BERR     (I_VME_BERR)
    );

    initial I_CLK_32M = 1'b0;
    always #5 I_CLK_32M = ~I_CLK_32M;

    // Every observation is taken 1 ns after a rising edge.
    task automatic tick();
        @(posedge I_CLK_32M);
        #1;
    endtask

    task automatic apply_stimulus(input logic wr, input logic [14:0] addr, input logic [5:0] am,
                                  input logic [1:0] be, input logic [15:0] data);
        I_REQ_WR   = wr;
        I_REQ_ADDR = addr;
        I_REQ_AM   = am;
        I_REQ_BE   = be;
        I_REQ_DATA = data;
        I_REQ      = 1'b1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic wait_done(input int budget, output int n);
        n = 0;
        while (O_DONE !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        I_VME_SYSRESET = 1'b1;
        I_REQ       = 1'b0;
        I_REQ_WR    = 1'b0;
        I_REQ_ADDR  = '0;
        I_REQ_AM    = '0;
        I_REQ_BE    = '0;
        I_REQ_DATA  = '0;
        I_VME_D     = '0;
        I_VME_DTACK = 1'b1;
        I_VME_BERR  = 1'b1;
        #1 I_VME_SYSRESET = 1'b0;
        #2;
        $display("[TB] reset values");
        check_output("rst AS", O_VME_AS, 1);
        check_output("rst DS0", O_VME_DS0, 1);
        check_output("rst DS1", O_VME_DS1, 1);
        check_output("rst WR", O_VME_WR, 1);
        check_output("rst LWORD", O_VME_LWORD, 1);
        check_output("rst D_OE", O_VME_D_OE, 0);
        check_output("rst BUSY", O_BUSY, 0);
        check_output("rst DONE", O_DONE, 0);
        check_output("rst STATUS", O_STATUS, 0);
        check_output("rst A", O_VME_A, 0);
        check_output("rst AM", O_VME_AM, 0);
        check_output("rst D", O_VME_D, 0);
        check_output("rst RD_DATA", O_RD_DATA, 0);
        tick();
        tick();
        I_VME_SYSRESET = 1'b1;
        tick();

        $display("[TB] write 0x1234, BE=11, DTACK 5 cycles after DS");
        apply_stimulus(1'b1, 15'h00A4, 6'h29, 2'b11, 16'h1234);
        tick();
        I_REQ = 1'b0;
        check_output("w1 BUSY", O_BUSY, 1);
        tick();
        check_output("w1 A", O_VME_A, 15'h00A4);
        check_output("w1 AM", O_VME_AM, 6'h29);
        check_output("w1 WR", O_VME_WR, 0);
        check_output("w1 D", O_VME_D, 16'h1234);
        check_output("w1 D_OE setup", O_VME_D_OE, 1);
        check_output("w1 AS setup1", O_VME_AS, 1);
        tick();
        check_output("w1 AS setup2", O_VME_AS, 1);
        tick();
        check_output("w1 AS low", O_VME_AS, 0);
        check_output("w1 DS0 before", O_VME_DS0, 1);
        tick();
        check_output("w1 DS0", O_VME_DS0, 0);
        check_output("w1 DS1", O_VME_DS1, 0);
        repeat (5) tick();
        I_VME_DTACK = 1'b0;
        repeat (3) tick();
        check_output("w1 AS released", O_VME_AS, 1);
        check_output("w1 DS0 released", O_VME_DS0, 1);
        check_output("w1 D_OE hold", O_VME_D_OE, 1);
        tick();
        check_output("w1 D_OE off", O_VME_D_OE, 0);
        tick();
        I_VME_DTACK = 1'b1;
        check_output("w1 A stable", O_VME_A, 15'h00A4);
        wait_done(10, cycles);
        check_output("w1 DONE", O_DONE, 1);
        check_output("w1 done latency", cycles, 4);
        check_output("w1 STATUS", O_STATUS, 2'b00);
        check_output("w1 BUSY idle", O_BUSY, 0);
        tick();
        check_output("w1 DONE pulse", O_DONE, 0);

        $display("[TB] read BE=01 returning 0xBEEF");
        apply_stimulus(1'b0, 15'h0010, 6'h29, 2'b01, 16'h0000);
        tick();
        I_REQ   = 1'b0;
        I_VME_D = 16'hBEEF;
        repeat (4) tick();
        check_output("r1 DS0", O_VME_DS0, 0);
        check_output("r1 DS1", O_VME_DS1, 1);
        check_output("r1 WR", O_VME_WR, 1);
        check_output("r1 D_OE", O_VME_D_OE, 0);
        I_VME_DTACK = 1'b0;
        repeat (3) tick();
        check_output("r1 AS released", O_VME_AS, 1);
        check_output("r1 RD held", O_RD_DATA, 16'h0000);
        I_VME_DTACK = 1'b1;
        I_VME_D     = 16'h0000;
        wait_done(10, cycles);
        check_output("r1 DONE", O_DONE, 1);
        check_output("r1 done latency", cycles, 4);
        check_output("r1 RD_DATA", O_RD_DATA, 16'hBEEF);
        check_output("r1 STATUS", O_STATUS, 2'b00);

        $display("[TB] read with BERR");
        apply_stimulus(1'b0, 15'h0020, 6'h29, 2'b10, 16'h0000);
        tick();
        I_REQ   = 1'b0;
        I_VME_D = 16'h5555;
        repeat (4) tick();
        check_output("be DS1", O_VME_DS1, 0);
        check_output("be DS0", O_VME_DS0, 1);
        I_VME_BERR = 1'b0;
        repeat (3) tick();
        check_output("be DS1 released", O_VME_DS1, 1);
        I_VME_BERR = 1'b1;
        wait_done(10, cycles);
        check_output("be DONE", O_DONE, 1);
        check_output("be STATUS", O_STATUS, 2'b01);
        check_output("be RD unchanged", O_RD_DATA, 16'hBEEF);

        $display("[TB] no response, acknowledge timeout");
        apply_stimulus(1'b0, 15'h0030, 6'h29, 2'b11, 16'h0000);
        tick();
        I_REQ = 1'b0;
        repeat (5) tick();
        check_output("to DS0 first wait", O_VME_DS0, 0);
        repeat (5) tick();
        I_REQ = 1'b1;
        tick();
        I_REQ = 1'b0;
        repeat (9) tick();
        check_output("to DS0 last wait", O_VME_DS0, 0);
        tick();
        check_output("to DS0 released", O_VME_DS0, 1);
        check_output("to AS released", O_VME_AS, 1);
        wait_done(10, cycles);
        check_output("to DONE", O_DONE, 1);
        check_output("to done latency", cycles, 3);
        check_output("to STATUS", O_STATUS, 2'b10);
        tick();
        tick();
        check_output("to busy request ignored", O_BUSY, 0);

        $display("[TB] DTACK stuck low, release timeout");
        apply_stimulus(1'b1, 15'h0040, 6'h2D, 2'b11, 16'hF00D);
        tick();
        I_REQ = 1'b0;
        repeat (4) tick();
        I_VME_DTACK = 1'b0;
        repeat (3) tick();
        check_output("st AS released", O_VME_AS, 1);
        wait_done(30, cycles);
        check_output("st DONE", O_DONE, 1);
        check_output("st done latency", cycles, 18);
        check_output("st STATUS", O_STATUS, 2'b10);
        repeat (22) tick();
        I_VME_DTACK = 1'b1;
        repeat (3) tick();

        $display("[TB] illegal byte enables");
        apply_stimulus(1'b1, 15'h0050, 6'h29, 2'b00, 16'hAAAA);
        tick();
        I_REQ = 1'b0;
        check_output("bz BUSY", O_BUSY, 1);
        check_output("bz DONE early", O_DONE, 0);
        check_output("bz AS", O_VME_AS, 1);
        tick();
        check_output("bz DONE", O_DONE, 1);
        check_output("bz STATUS", O_STATUS, 2'b11);
        check_output("bz AS idle", O_VME_AS, 1);
        check_output("bz D_OE", O_VME_D_OE, 0);
        tick();
        check_output("bz DONE pulse", O_DONE, 0);

        $display("[TB] reset during WAIT_ACK");
        apply_stimulus(1'b1, 15'h0060, 6'h29, 2'b11, 16'h7777);
        tick();
        I_REQ = 1'b0;
        repeat (6) tick();
        check_output("mr AS low", O_VME_AS, 0);
        check_output("mr D_OE on", O_VME_D_OE, 1);
        #2 I_VME_SYSRESET = 1'b0;
        #1;
        check_output("mr AS async", O_VME_AS, 1);
        check_output("mr DS0 async", O_VME_DS0, 1);
        check_output("mr DS1 async", O_VME_DS1, 1);
        check_output("mr D_OE async", O_VME_D_OE, 0);
        check_output("mr BUSY async", O_BUSY, 0);
        tick();
        tick();
        I_VME_SYSRESET = 1'b1;
        tick();
        check_output("mr no DONE", O_DONE, 0);
        check_output("mr STATUS", O_STATUS, 2'b00);
        apply_stimulus(1'b0, 15'h0070, 6'h29, 2'b11, 16'h0000);
        tick();
        I_REQ   = 1'b0;
        I_VME_D = 16'hC0DE;
        repeat (4) tick();
        I_VME_DTACK = 1'b0;
        repeat (3) tick();
        I_VME_DTACK = 1'b1;
        wait_done(10, cycles);
        check_output("mr2 DONE", O_DONE, 1);
        check_output("mr2 done latency", cycles, 4);
        check_output("mr2 RD_DATA", O_RD_DATA, 16'hC0DE);

        $display("[TB] back-to-back with request held");
        apply_stimulus(1'b0, 15'h0080, 6'h29, 2'b01, 16'h0000);
        I_VME_D = 16'h1111;
        tick();
        repeat (4) tick();
        I_VME_DTACK = 1'b0;
        repeat (3) tick();
        I_VME_DTACK = 1'b1;
        wait_done(10, cycles);
        check_output("bb1 DONE", O_DONE, 1);
        check_output("bb1 done latency", cycles, 4);
        check_output("bb1 BUSY idle", O_BUSY, 0);
        check_output("bb1 RD_DATA", O_RD_DATA, 16'h1111);
        tick();
        check_output("bb2 accepted", O_BUSY, 1);
        I_REQ   = 1'b0;
        I_VME_D = 16'h2222;
        repeat (2) tick();
        check_output("bb2 AS setup", O_VME_AS, 1);
        tick();
        check_output("bb2 AS low", O_VME_AS, 0);
        tick();
        check_output("bb2 DS0", O_VME_DS0, 0);
        I_VME_DTACK = 1'b0;
        repeat (3) tick();
        I_VME_DTACK = 1'b1;
        wait_done(10, cycles);
        check_output("bb2 DONE", O_DONE, 1);
        check_output("bb2 done latency", cycles, 4);
        check_output("bb2 RD_DATA", O_RD_DATA, 16'h2222);
        check_output("bb2 STATUS", O_STATUS, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
